// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the CPU bus arbiter: FSM encoding,
// round-robin index arithmetic and packed-vector slice addressing.
package cpu_bus_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Wraps an index that may have run at most one port past the end.
    function automatic int wrap_idx(input int idx, input int num_ports);
        return (idx >= num_ports) ? idx - num_ports : idx;
    endfunction

    function automatic int rr_next(input int idx, input int num_ports);
        return wrap_idx(idx + 1, num_ports);
    endfunction

    function automatic int slice_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/cpu_bus_arb_select.sv
// Combinational winner pick: highest set index in fixed mode, or the first
// set index at or above the pointer (wrapping) in round-robin mode.
module cpu_bus_arb_select
    import cpu_bus_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int GW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GW-1:0]        ptr,
    input  logic                 rr_mode,
    output logic [GW-1:0]        winner,
    output logic                 valid
);

    int best;
    int rank;

    // Each requester gets a rank (lower wins); the scan keeps the best one.
    always_comb begin
        winner = '0;
        valid  = |req;
        best   = NUM_PORTS;
        rank   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rr_mode)
                rank = (i >= int'(ptr)) ? i - int'(ptr) : i + NUM_PORTS - int'(ptr);
            else
                rank = NUM_PORTS - 1 - i;
            if (req[i] && rank < best) begin
                best   = rank;
                winner = GW'(i);
            end
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// N-port arbiter muxing CPU-side requesters onto one single-outstanding bus
// master, with fixed or round-robin priority and an optional bus timeout.
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RR_MODE    = 0,
    parameter int TIMEOUT    = 0,
    parameter int GW         = $clog2(NUM_PORTS)
) (
    input  logic                            i_clock,
    input  logic                            i_reset_n,
    output logic                            o_bus_rw,
    output logic                            o_bus_request,
    input  logic                            i_bus_ready,
    output logic [ADDR_WIDTH-1:0]           o_bus_address,
    input  logic [DATA_WIDTH-1:0]           i_bus_rdata,
    output logic [DATA_WIDTH-1:0]           o_bus_wdata,
    input  logic [NUM_PORTS-1:0]            i_rw,
    input  logic [NUM_PORTS-1:0]            i_request,
    output logic [NUM_PORTS-1:0]            o_ready,
    output logic [NUM_PORTS-1:0]            o_error,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_wdata,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] o_rdata,
    output logic [GW-1:0]                   o_grant
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   rr_ptr;
    logic [TW-1:0]   tmo_cnt;
    logic [GW-1:0]   win;
    logic            win_valid;
    logic            tmo_hit;

    cpu_bus_arb_select #(
        .NUM_PORTS(NUM_PORTS),
        .GW       (GW)
    ) u_select (
        .req    (i_request),
        .ptr    (rr_ptr),
        .rr_mode(RR_MODE != 0),
        .winner (win),
        .valid  (win_valid)
    );

    assign o_bus_request = (state == ACTIVE);
    assign o_grant       = grant_q;
    assign tmo_hit       = (TIMEOUT > 0) && (state == ACTIVE) && !i_bus_ready
                           && (tmo_cnt == TMO_LAST);

    // Only the granted slot ever sees a strobe; an errored read returns zero.
    always_comb begin
        o_ready = '0;
        o_error = '0;
        o_rdata = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (state == ACTIVE && grant_q == GW'(k)) begin
                o_ready[k] = (i_bus_ready || tmo_hit) && i_request[k];
                o_error[k] = tmo_hit && i_request[k];
                if (!i_rw[k] && !tmo_hit)
                    o_rdata[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH] = i_bus_rdata;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            o_bus_rw      <= 1'b0;
            o_bus_address <= '0;
            o_bus_wdata   <= '0;
            grant_q       <= '0;
            rr_ptr        <= '0;
            tmo_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        o_bus_rw      <= i_rw[win];
                        o_bus_address <= i_address[slice_lo(int'(win), ADDR_WIDTH) +: ADDR_WIDTH];
                        o_bus_wdata   <= i_wdata[slice_lo(int'(win), DATA_WIDTH) +: DATA_WIDTH];
                        grant_q       <= win;
                        rr_ptr        <= GW'(rr_next(int'(win), NUM_PORTS));
                        tmo_cnt       <= '0;
                        state         <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (i_bus_ready || tmo_hit)
                        state <= IDLE;
                    else if (TIMEOUT > 0)
                        tmo_cnt <= tmo_cnt + TW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench: a 4-port fixed-priority arbiter with a 4-cycle timeout and
// a 3-port round-robin arbiter without timeout, sharing clock and reset.
module tb_cpu_bus_arbiter;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    // fixed-priority instance
    logic         f_bus_rw, f_bus_req, f_bready;
    logic [31:0]  f_bus_addr, f_brdata, f_bus_wdata;
    logic [3:0]   f_rw, f_req, f_ready, f_error;
    logic [127:0] f_addr, f_wdata, f_rdata;
    logic [1:0]   f_grant;

    // round-robin instance
    logic        r_bus_rw, r_bus_req, r_bready;
    logic [31:0] r_bus_addr, r_brdata, r_bus_wdata;
    logic [2:0]  r_rw, r_req, r_ready, r_error;
    logic [95:0] r_addr, r_wdata, r_rdata;
    logic [1:0]  r_grant;

    cpu_bus_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(0), .TIMEOUT(4)) dut_fx (
        .i_clock(clk), .i_reset_n(rst_n), .o_bus_rw(f_bus_rw), .o_bus_request(f_bus_req),
        .i_bus_ready(f_bready), .o_bus_address(f_bus_addr), .i_bus_rdata(f_brdata),
        .o_bus_wdata(f_bus_wdata), .i_rw(f_rw), .i_request(f_req), .o_ready(f_ready),
        .o_error(f_error), .i_address(f_addr), .i_wdata(f_wdata), .o_rdata(f_rdata),
        .o_grant(f_grant)
    );

    cpu_bus_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1), .TIMEOUT(0)) dut_rr (
        .i_clock(clk), .i_reset_n(rst_n), .o_bus_rw(r_bus_rw), .o_bus_request(r_bus_req),
        .i_bus_ready(r_bready), .o_bus_address(r_bus_addr), .i_bus_rdata(r_brdata),
        .o_bus_wdata(r_bus_wdata), .i_rw(r_rw), .i_request(r_req), .o_ready(r_ready),
        .o_error(r_error), .i_address(r_addr), .i_wdata(r_wdata), .o_rdata(r_rdata),
        .o_grant(r_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total_cnt++; if (f_bus_req !== 1'b0) $display("FAIL reset_f_bus_req got %b exp 0", f_bus_req); else pass_cnt++;
        total_cnt++; if (f_bus_addr !== 32'h0) $display("FAIL reset_f_bus_addr got %h exp 0", f_bus_addr); else pass_cnt++;
        total_cnt++; if (f_grant !== 2'd0) $display("FAIL reset_f_grant got %0d exp 0", f_grant); else pass_cnt++;
        total_cnt++; if (f_ready !== 4'b0 || f_error !== 4'b0) $display("FAIL reset_f_strobes got %b/%b exp 0000/0000", f_ready, f_error); else pass_cnt++;
        total_cnt++; if (r_bus_rw !== 1'b0 || r_bus_wdata !== 32'h0) $display("FAIL reset_r_bus_regs got %b/%h exp 0/0", r_bus_rw, r_bus_wdata); else pass_cnt++;
        total_cnt++; if (r_rdata !== 96'h0) $display("FAIL reset_r_rdata got %h exp 0", r_rdata); else pass_cnt++;
        #20;
        rst_n = 1'b1;
    endtask

    task automatic test_fixed_prio();
        f_req = 4'b0101; f_rw = 4'b0100;
        tick();
        total_cnt++; if (f_bus_req !== 1'b1) $display("FAIL fixed_bus_req got %b exp 1", f_bus_req); else pass_cnt++;
        total_cnt++; if (f_grant !== 2'd2) $display("FAIL fixed_grant got %0d exp 2", f_grant); else pass_cnt++;
        total_cnt++; if (f_bus_addr !== 32'h0000_2000) $display("FAIL fixed_addr got %h exp 00002000", f_bus_addr); else pass_cnt++;
        total_cnt++; if (f_bus_rw !== 1'b1 || f_bus_wdata !== 32'hAAAA_0002) $display("FAIL fixed_write got %b/%h exp 1/aaaa0002", f_bus_rw, f_bus_wdata); else pass_cnt++;
        total_cnt++; if (f_ready !== 4'b0000) $display("FAIL fixed_ready_early got %b exp 0000", f_ready); else pass_cnt++;
        f_bready = 1'b1;
        #1;
        total_cnt++; if (f_ready !== 4'b0100 || f_error !== 4'b0000) $display("FAIL fixed_ready got %b/%b exp 0100/0000", f_ready, f_error); else pass_cnt++;
        tick();
        f_req = 4'b0; f_bready = 1'b0; f_rw = 4'b0;
        #1;
        total_cnt++; if (f_bus_req !== 1'b0) $display("FAIL fixed_idle got %b exp 0", f_bus_req); else pass_cnt++;
    endtask

    task automatic test_read_rdata();
        f_req = 4'b0010; f_rw = 4'b0000;
        tick();
        f_bready = 1'b1; f_brdata = 32'hDEAD_BEEF;
        #1;
        total_cnt++; if (f_rdata !== 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000) $display("FAIL read_rdata got %h exp slice1=deadbeef", f_rdata); else pass_cnt++;
        total_cnt++; if (f_ready !== 4'b0010 || f_bus_rw !== 1'b0) $display("FAIL read_ready got %b/%b exp 0010/0", f_ready, f_bus_rw); else pass_cnt++;
        tick();
        f_req = 4'b0; f_bready = 1'b0; f_brdata = 32'h0;
        #1;
        total_cnt++; if (f_rdata !== 128'h0) $display("FAIL read_rdata_idle got %h exp 0", f_rdata); else pass_cnt++;
    endtask

    task automatic test_timeout_expire();
        f_req = 4'b1000; f_rw = 4'b0000; f_brdata = 32'h1234_5678;
        tick();
        total_cnt++; if (f_ready !== 4'b0 || f_error !== 4'b0) $display("FAIL tmo_cycle1 got %b/%b exp 0000/0000", f_ready, f_error); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (f_error !== 4'b0 || f_bus_req !== 1'b1) $display("FAIL tmo_cycle3 got err %b req %b exp 0000/1", f_error, f_bus_req); else pass_cnt++;
        tick();
        total_cnt++; if (f_ready !== 4'b1000 || f_error !== 4'b1000) $display("FAIL tmo_cycle4 got %b/%b exp 1000/1000", f_ready, f_error); else pass_cnt++;
        total_cnt++; if (f_rdata !== 128'h0) $display("FAIL tmo_rdata got %h exp 0", f_rdata); else pass_cnt++;
        tick();
        total_cnt++; if (f_bus_req !== 1'b0 || f_error !== 4'b0) $display("FAIL tmo_after got req %b err %b exp 0/0000", f_bus_req, f_error); else pass_cnt++;
        f_req = 4'b0; f_brdata = 32'h0;
    endtask

    task automatic test_timeout_ready_wins();
        f_req = 4'b0001; f_rw = 4'b0001;
        tick();
        tick();
        tick();
        tick();
        f_bready = 1'b1;
        #1;
        total_cnt++; if (f_ready !== 4'b0001 || f_error !== 4'b0000) $display("FAIL race_strobes got %b/%b exp 0001/0000", f_ready, f_error); else pass_cnt++;
        tick();
        f_req = 4'b0; f_bready = 1'b0; f_rw = 4'b0;
        #1;
        total_cnt++; if (f_bus_req !== 1'b0) $display("FAIL race_after got %b exp 0", f_bus_req); else pass_cnt++;
    endtask

    task automatic test_drop_request();
        f_req = 4'b0010;
        tick();
        f_req = 4'b0000; f_bready = 1'b1;
        #1;
        total_cnt++; if (f_ready !== 4'b0000 || f_bus_req !== 1'b1) $display("FAIL drop_masked got ready %b req %b exp 0000/1", f_ready, f_bus_req); else pass_cnt++;
        tick();
        f_bready = 1'b0;
        #1;
        total_cnt++; if (f_bus_req !== 1'b0) $display("FAIL drop_done got %b exp 0", f_bus_req); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g [4];
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd0};
        r_req = 3'b111; r_bready = 1'b1;
        foreach (exp_g[i]) begin
            tick();
            total_cnt++;
            if (r_bus_req !== 1'b1 || r_grant !== exp_g[i] || r_ready !== (3'b001 << exp_g[i]))
                $display("FAIL rr_grant%0d got req %b grant %0d ready %b exp 1/%0d/%b",
                         i, r_bus_req, r_grant, r_ready, exp_g[i], 3'b001 << exp_g[i]);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (r_bus_req !== 1'b0 || r_ready !== 3'b000)
                $display("FAIL rr_idle%0d got req %b ready %b exp 0/000", i, r_bus_req, r_ready);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        r_req = 3'b011; r_bready = 1'b0;
        tick();
        total_cnt++; if (r_grant !== 2'd1 || r_bus_addr !== 32'h0000_1000) $display("FAIL mid_grant got %0d/%h exp 1/00001000", r_grant, r_bus_addr); else pass_cnt++;
        #3;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (r_bus_req !== 1'b0) $display("FAIL mid_req_drop got %b exp 0", r_bus_req); else pass_cnt++;
        total_cnt++; if (r_bus_addr !== 32'h0 || r_grant !== 2'd0 || r_bus_wdata !== 32'h0) $display("FAIL mid_regs got %h/%0d/%h exp 0/0/0", r_bus_addr, r_grant, r_bus_wdata); else pass_cnt++;
        #2;
        rst_n = 1'b1;
        r_req = 3'b101;
        tick();
        total_cnt++; if (r_grant !== 2'd0 || r_bus_req !== 1'b1) $display("FAIL mid_ptr_reset got grant %0d req %b exp 0/1", r_grant, r_bus_req); else pass_cnt++;
        r_req = 3'b000; r_bready = 1'b1;
        tick();
        r_bready = 1'b0;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        f_rw = '0; f_req = '0; f_bready = 1'b0; f_brdata = '0;
        f_addr  = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
        f_wdata = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
        r_rw = '0; r_req = '0; r_bready = 1'b0; r_brdata = '0;
        r_addr  = {32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
        r_wdata = {32'hBBBB_0002, 32'hBBBB_0001, 32'hBBBB_0000};
        test_reset();
        test_fixed_prio();
        test_read_rdata();
        test_timeout_expire();
        test_timeout_ready_wins();
        test_drop_request();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- N-port bus arbiter that muxes NUM_PORTS requesters onto one single-outstanding CPU bus master interface.
- Successor to the two-port fixed-priority bus access block. Adds parametrised port count and widths, selectable fixed or round-robin priority, and a per-transaction bus timeout with error reporting.
- Sits between CPU-side requesters (fetch, load/store, debug, DMA) and the system bus.

Parameters:
- NUM_PORTS, 2: number of requester ports; legal range 2..8.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width.
- RR_MODE, 0: 0 = fixed priority (highest index wins); 1 = round-robin.
- TIMEOUT, 0: maximum cycles spent in ACTIVE waiting for i_bus_ready; 0 disables the timeout.
- GW, $clog2(NUM_PORTS): width of the grant index (derived).

Ports:
- i_clock  in  1  clock; all logic on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- o_bus_rw  out  1  bus direction; 1 = write.
- o_bus_request  out  1  bus transaction active.
- i_bus_ready  in  1  bus transaction complete.
- o_bus_address  out  ADDR_WIDTH  latched address.
- i_bus_rdata  in  DATA_WIDTH  read data.
- o_bus_wdata  out  DATA_WIDTH  latched write data.
- i_rw  in  NUM_PORTS  per-port direction.
- i_request  in  NUM_PORTS  per-port request level.
- o_ready  out  NUM_PORTS  per-port completion strobe.
- o_error  out  NUM_PORTS  per-port timeout strobe; coincident with o_ready.
- i_address  in  NUM_PORTS*ADDR_WIDTH  packed; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- i_wdata  in  NUM_PORTS*DATA_WIDTH  packed, same layout.
- o_rdata  out  NUM_PORTS*DATA_WIDTH  packed, same layout.
- o_grant  out  GW  index of the port currently granted; valid only while o_bus_request is high.

Behaviour:
- Reset (async assert, synchronous release):
  - state = IDLE; o_bus_rw, o_bus_address and o_bus_wdata = 0.
  - Grant index = 0; RR pointer = 0; timeout counter = 0.
  - All combinational outputs therefore read 0.
- States: IDLE and ACTIVE. o_bus_request = (state == ACTIVE).
- IDLE:
  - If any i_request bit is set, select winner w.
  - Latch i_rw[w], address slice w and wdata slice w onto the bus registers.
  - Register grant = w and go to ACTIVE; bus request rises on the next cycle.
  - If no request is set, stay in IDLE; registers hold their values.
- Winner selection:
  - RR_MODE = 0: highest set index.
  - RR_MODE = 1: first set index scanning upward from pointer, wrapping past NUM_PORTS-1 to 0. On each grant, pointer <= w+1 (mod NUM_PORTS, wrap without overflow for non-power-of-2 counts).
- ACTIVE:
  - o_ready[grant] = i_bus_ready & i_request[grant] (combinational); all other ready bits are 0.
  - o_rdata slice[grant] = i_bus_rdata when i_rw[grant] == 0 & ACTIVE; otherwise 0. No tri-state drive.
  - On i_bus_ready: go to IDLE. There is one mandatory IDLE cycle between transactions.
- Timeout (TIMEOUT > 0):
  - Counter clears on entry to ACTIVE and increments each ACTIVE cycle with i_bus_ready low.
  - When counter == TIMEOUT-1 and i_bus_ready is low: assert o_ready[grant] and o_error[grant] for that cycle, then go to IDLE.
  - Read data for the errored transaction is 0.
  - If ready and timeout expiry coincide, ready wins and no error is raised.
- A requester that drops i_request mid-transaction does not abort the bus cycle. The arbiter stays ACTIVE until ready or timeout; the ready strobe is masked because the request is low.
- Requests arriving while ACTIVE wait; they are not latched.
- Asynchronous reset mid-transaction: immediate return to reset state; bus request drops without waiting for ready.
- Latency: request sampled at edge n; bus request high from edge n; minimum port ready in cycle n+1 for a zero-wait bus.

Decomposition:
- Shared package cpu_bus_pkg:
  - State encoding localparams (IDLE = 1'b0, ACTIVE = 1'b1).
  - Function for round-robin next index.
  - Packed-slice index helper.
- One sub-module: cpu_bus_arb_select. Purely combinational. Inputs: request vector, pointer, mode. Outputs: winner index and any-valid flag. Kept separate so it can be unit-tested exhaustively.

Test Plan:
- Fixed mode, NUM_PORTS = 4: i_request = 4'b0101 in IDLE -> grant 2. Bus address = port 2 address (e.g. 0x0000_2000). o_ready = 4'b0100 on the bus-ready cycle.
- RR mode, NUM_PORTS = 3: requests 3'b111 held continuously -> grants 0, 1, 2, 0. Each transaction is followed by exactly one IDLE cycle.
- Read on port 1 with i_bus_rdata = 0xDEADBEEF -> o_rdata slice 1 = 0xDEADBEEF during ready; all other slices 0.
- TIMEOUT = 4, bus ready never asserted -> o_ready and o_error pulse on the 4th ACTIVE cycle; bus request low on the next cycle.
- TIMEOUT = 4, ready on the 4th cycle -> o_ready high and o_error low.
- Assert i_reset_n low while ACTIVE -> o_bus_request falls without waiting for a clock edge, and all registered outputs read 0. After release, the first grant in RR mode goes to the lowest set request index (pointer back to 0).
